// File: rtl/csr_cnt_pkg.sv
// csr_cnt_pkg: shared channel indices, default widths and half-select type for the counter bank
package csr_cnt_pkg;
    localparam int CNT_CYCLE    = 0;
    localparam int CNT_INSTRET  = 1;
    localparam int CNT_HPM_BASE = 2;
    localparam int DEF_XLEN     = 32;
    localparam int DEF_CNT_W    = 64;
    typedef enum logic {LO = 1'b0, HI = 1'b1} cnt_half_e;
endpackage

// File: rtl/csr_cnt_slice.sv
// csr_cnt_slice: one performance counter with half-writes and a sticky wrap flag
module csr_cnt_slice
    import csr_cnt_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int XLEN  = DEF_XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, wrap;

    // a write replaces one half and swallows this cycle's increment; wrap beats any clear
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo)
            cnt_d[XLEN-1:0] = wr_data;
        else if (wr_hi)
            cnt_d[CNT_W-1:XLEN] = wr_data[CNT_W-XLEN-1:0];
        else if (inc)
            cnt_d = cnt_q + CNT_W'(1);
        wrap  = inc & ~wr_lo & ~wr_hi & (&cnt_q);
        ovf_d = wrap ? 1'b1 : (ovf_clr | wr_lo | wr_hi) ? 1'b0 : ovf_q;
    end

    // counter and flag state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;
endmodule

// File: rtl/csr_cnt_bank.sv
// csr_cnt_bank: bank of gated performance counters with registered CSR half reads and half writes
module csr_cnt_bank
    import csr_cnt_pkg::*;
#(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int XLEN    = DEF_XLEN,
    parameter int IDX_W   = $clog2(NUM_CNT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CNT-1:0] evt,
    input  logic               hold,
    input  logic               inh_we,
    input  logic [NUM_CNT-1:0] inh_data,
    output logic [NUM_CNT-1:0] inh,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic               rd_hi,
    output logic               rd_valid,
    output logic [XLEN-1:0]    rd_data,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_hi,
    input  logic [XLEN-1:0]    wr_data,
    output logic [NUM_CNT-1:0] ovf,
    input  logic [NUM_CNT-1:0] ovf_clr
);
    logic                armed_q, armed_d;
    logic [NUM_CNT-1:0]  inh_q, inh_d;
    logic                rd_valid_q, rd_valid_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic [NUM_CNT-1:0]  inc, wr_lo_v, wr_hi_v;
    logic [CNT_W-1:0]    cnt [NUM_CNT];
    logic [CNT_W-1:0]    sel;

    // per-channel gating and decode; out-of-range indices match no channel, so reads give 0
    always_comb begin
        inc     = '0;
        wr_lo_v = '0;
        wr_hi_v = '0;
        sel     = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            inc[k]     = armed_q & evt[k] & ~hold & ~inh_q[k];
            wr_lo_v[k] = wr_en & (wr_idx == IDX_W'(k)) & (cnt_half_e'(wr_hi) == LO);
            wr_hi_v[k] = wr_en & (wr_idx == IDX_W'(k)) & (cnt_half_e'(wr_hi) == HI);
            if (rd_idx == IDX_W'(k))
                sel = cnt[k];
        end
    end

    // arm, inhibit and read-register next state; reads see the pre-update counter value
    always_comb begin
        armed_d    = 1'b1;
        inh_d      = inh_we ? inh_data : inh_q;
        rd_valid_d = rd_req;
        rd_data_d  = rd_req ? ((cnt_half_e'(rd_hi) == HI) ? XLEN'(sel[CNT_W-1:XLEN]) : sel[XLEN-1:0])
                            : rd_data_q;
    end

    // control and read state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q    <= 1'b0;
            inh_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            armed_q    <= armed_d;
            inh_q      <= inh_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        csr_cnt_slice #(.CNT_W(CNT_W), .XLEN(XLEN)) u_slice (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (inc[i]),
            .wr_lo   (wr_lo_v[i]),
            .wr_hi   (wr_hi_v[i]),
            .wr_data (wr_data),
            .ovf_clr (ovf_clr[i]),
            .cnt     (cnt[i]),
            .ovf     (ovf[i])
        );
    end

    assign inh      = inh_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_csr_cnt_bank.sv
// tb_csr_cnt_bank: directed self-checking bench for the performance counter bank
module tb_csr_cnt_bank;
    localparam int N  = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  evt, inh_data, inh, ovf, ovf_clr;
    logic          hold, inh_we, rd_req, rd_hi, rd_valid, wr_en, wr_hi;
    logic [IW-1:0] rd_idx, wr_idx;
    logic [31:0]   rd_data, wr_data;
    int            tests = 0;
    int            failed = 0;
    logic [31:0]   d;
    logic          v;

    csr_cnt_bank #(.NUM_CNT(N), .CNT_W(64), .XLEN(32), .IDX_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .evt(evt), .hold(hold), .inh_we(inh_we),
        .inh_data(inh_data), .inh(inh), .rd_req(rd_req), .rd_idx(rd_idx),
        .rd_hi(rd_hi), .rd_valid(rd_valid), .rd_data(rd_data), .wr_en(wr_en),
        .wr_idx(wr_idx), .wr_hi(wr_hi), .wr_data(wr_data), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int idx, input logic hi, output logic [31:0] dd, output logic vv);
        rd_req = 1'b1; rd_idx = IW'(idx); rd_hi = hi;
        step();
        dd = rd_data; vv = rd_valid;
        rd_req = 1'b0;
    endtask

    task automatic wr(input int idx, input logic hi, input logic [31:0] data);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_hi = hi; wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL reset_rd_valid got %0h exp 0", rd_valid); end
        tests++; if (rd_data !== 32'h0) begin failed++; $display("FAIL reset_rd_data got %0h exp 0", rd_data); end
        tests++; if (ovf !== 4'h0) begin failed++; $display("FAIL reset_ovf got %0h exp 0", ovf); end
        tests++; if (inh !== 4'h0) begin failed++; $display("FAIL reset_inh got %0h exp 0", inh); end
    endtask

    task automatic test_count();
        rst_n = 1'b1;
        evt = '1;
        repeat (10) step();
        rd(0, 1'b0, d, v);
        tests++; if (d !== 32'd9) begin failed++; $display("FAIL count_lo got %0d exp 9", d); end
        tests++; if (v !== 1'b1) begin failed++; $display("FAIL count_valid got %0h exp 1", v); end
        rd(0, 1'b1, d, v);
        tests++; if (d !== 32'd0) begin failed++; $display("FAIL count_hi got %0h exp 0", d); end
        evt = '0;
    endtask

    task automatic test_hold_inh();
        wr(1, 1'b0, 0); wr(2, 1'b0, 0); wr(3, 1'b0, 0);
        inh_we = 1'b1; inh_data = 4'b0100;
        step();
        inh_we = 1'b0;
        tests++; if (inh !== 4'b0100) begin failed++; $display("FAIL inh_load got %0h exp 4", inh); end
        evt = 4'b1110;
        for (int c = 0; c < 20; c++) begin
            hold = (c >= 5 && c < 10);
            step();
        end
        hold = 1'b0; evt = '0;
        rd(1, 1'b0, d, v);
        tests++; if (d !== 32'd15) begin failed++; $display("FAIL hold_ch1 got %0d exp 15", d); end
        rd(2, 1'b0, d, v);
        tests++; if (d !== 32'd0) begin failed++; $display("FAIL inh_ch2 got %0d exp 0", d); end
        rd(3, 1'b0, d, v);
        tests++; if (d !== 32'd15) begin failed++; $display("FAIL hold_ch3 got %0d exp 15", d); end
        inh_we = 1'b1; inh_data = '0;
        step();
        inh_we = 1'b0;
    endtask

    task automatic test_wrap();
        wr(0, 1'b0, 32'hFFFF_FFFF); wr(0, 1'b1, 32'hFFFF_FFFF);
        evt = 4'b0001;
        step();
        evt = '0;
        tests++; if (ovf !== 4'b0001) begin failed++; $display("FAIL wrap_ovf got %0h exp 1", ovf); end
        rd(0, 1'b0, d, v);
        tests++; if (d !== 32'd0) begin failed++; $display("FAIL wrap_lo got %0h exp 0", d); end
        rd(0, 1'b1, d, v);
        tests++; if (d !== 32'd0) begin failed++; $display("FAIL wrap_hi got %0h exp 0", d); end
        tests++; if (ovf !== 4'b0001) begin failed++; $display("FAIL ovf_sticky got %0h exp 1", ovf); end
        ovf_clr = 4'b0001;
        step();
        ovf_clr = '0;
        tests++; if (ovf !== 4'b0000) begin failed++; $display("FAIL ovf_clr got %0h exp 0", ovf); end
        wr(0, 1'b0, 32'hFFFF_FFFF); wr(0, 1'b1, 32'hFFFF_FFFF);
        evt = 4'b0001;
        step();
        evt = '0;
        tests++; if (ovf !== 4'b0001) begin failed++; $display("FAIL wrap2_ovf got %0h exp 1", ovf); end
        wr(0, 1'b0, 32'd5);
        tests++; if (ovf !== 4'b0000) begin failed++; $display("FAIL wr_clr_ovf got %0h exp 0", ovf); end
    endtask

    task automatic test_write_wins();
        wr(1, 1'b1, 32'd7);
        evt = 4'b0010;
        wr(1, 1'b0, 32'h10);
        evt = '0;
        rd(1, 1'b0, d, v);
        tests++; if (d !== 32'h10) begin failed++; $display("FAIL write_wins_lo got %0h exp 10", d); end
        rd(1, 1'b1, d, v);
        tests++; if (d !== 32'd7) begin failed++; $display("FAIL write_keep_hi got %0h exp 7", d); end
    endtask

    task automatic test_back_to_back();
        rd_req = 1'b1; rd_idx = 3'd2; rd_hi = 1'b0;
        wr_en = 1'b1; wr_idx = 3'd2; wr_hi = 1'b0; wr_data = 32'hABCD;
        step();
        wr_en = 1'b0;
        tests++; if (rd_data !== 32'd0) begin failed++; $display("FAIL rw_old got %0h exp 0", rd_data); end
        step();
        tests++; if (rd_data !== 32'hABCD) begin failed++; $display("FAIL rw_new got %0h exp abcd", rd_data); end
        rd_idx = 3'd4;
        step();
        tests++; if (rd_data !== 32'd0) begin failed++; $display("FAIL oob_data got %0h exp 0", rd_data); end
        tests++; if (rd_valid !== 1'b1) begin failed++; $display("FAIL oob_valid got %0h exp 1", rd_valid); end
        rd_idx = 3'd1;
        step();
        tests++; if (rd_data !== 32'h10) begin failed++; $display("FAIL b2b_ch1 got %0h exp 10", rd_data); end
        rd_req = 1'b0;
        step();
        tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL valid_pulse got %0h exp 0", rd_valid); end
        tests++; if (rd_data !== 32'h10) begin failed++; $display("FAIL data_hold got %0h exp 10", rd_data); end
    endtask

    task automatic test_reset_mid();
        inh_we = 1'b1; inh_data = 4'b1000;
        step();
        inh_we = 1'b0;
        evt = '1; rd_req = 1'b1; rd_idx = 3'd1; rd_hi = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        tests++; if (rd_valid !== 1'b0) begin failed++; $display("FAIL mid_rd_valid got %0h exp 0", rd_valid); end
        tests++; if (rd_data !== 32'd0) begin failed++; $display("FAIL mid_rd_data got %0h exp 0", rd_data); end
        tests++; if (inh !== 4'h0) begin failed++; $display("FAIL mid_inh got %0h exp 0", inh); end
        tests++; if (ovf !== 4'h0) begin failed++; $display("FAIL mid_ovf got %0h exp 0", ovf); end
        rd_req = 1'b0; evt = 4'b0001;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        evt = '0;
        rd(0, 1'b0, d, v);
        tests++; if (d !== 32'd2) begin failed++; $display("FAIL rearm_ch0 got %0d exp 2", d); end
        rd(1, 1'b0, d, v);
        tests++; if (d !== 32'd0) begin failed++; $display("FAIL mid_ch1_cleared got %0h exp 0", d); end
    endtask

    initial begin
        rst_n = 1'b0; evt = '0; hold = 1'b0; inh_we = 1'b0; inh_data = '0;
        rd_req = 1'b0; rd_idx = '0; rd_hi = 1'b0; wr_en = 1'b0; wr_idx = '0;
        wr_hi = 1'b0; wr_data = '0; ovf_clr = '0;
        test_reset();
        test_count();
        test_hold_inh();
        test_wrap();
        test_write_wins();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
